// File: rtl/rca_pkg.sv
// rca_pkg: shared constants for the registered ripple-carry adder.
package rca_pkg;
    localparam int RCA_DEFAULT_N = 4;
endpackage

// File: rtl/rca_if.sv
// rca_if: operand/result bundle for rca_wrap; rca_port is the adder side, master drives operands.
interface rca_if import rca_pkg::*; #(parameter int N = RCA_DEFAULT_N) (input logic clk, input logic rst);
    logic         Ci;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] S;
    logic         Co;
    modport rca_port (input Ci, A, B, output S, Co);
    modport master (output Ci, A, B, input S, Co);
`ifndef SYNTHESIS
`include "rca_if_sva.svh"
`endif
endinterface

// File: rtl/rca_if_sva.svh
// rca_if_sva: result tracks the previous cycle's operands and clears after a reset edge.
a_sum: assert property (@(posedge clk) !rst |=> {Co, S} == $past({1'b0, A} + {1'b0, B} + {{N{1'b0}}, Ci}));
a_rst: assert property (@(posedge clk) rst |=> {Co, S} == '0);

// File: rtl/rca_wrap_full_adder.sv
// full_adder: one combinational cell of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_wrap.sv
// rca_wrap: N-bit ripple-carry adder with {Co, S} registered one cycle after the operands.
module rca_wrap import rca_pkg::*; #(parameter int N = RCA_DEFAULT_N) (
    input  logic   clk,
    input  logic   rst,
    rca_if.rca_port bus
);
    logic [N:0]   c;
    logic [N-1:0] s;
    logic [N:0]   sum_d;
    logic [N:0]   sum_q;
    assign c[0] = bus.Ci;
    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (.a(bus.A[i]), .b(bus.B[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
    end
    always_comb sum_d = {c[N], s};
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
    assign bus.S  = sum_q[N-1:0];
    assign bus.Co = sum_q[N];
endmodule

// File: tb/tb_rca_wrap.sv
// tb_rca_wrap: scoreboard bench for rca_wrap at N=4 with an N=8 width check.
module tb_rca_wrap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [4:0] exp_q[$];
    rca_if #(.N(4)) bus4 (.clk(clk), .rst(rst));
    rca_if #(.N(8)) bus8 (.clk(clk), .rst(rst));
    rca_wrap #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rca_wrap #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic r, input string tag);
        @(negedge clk);
        bus4.A = a;
        bus4.B = b;
        bus4.Ci = ci;
        rst = r;
        exp_q.push_back(r ? 5'd0 : ({1'b0, a} + {1'b0, b} + 5'(ci)));
        @(posedge clk);
        #1;
        check(tag, 9'({bus4.Co, bus4.S}), 9'(exp_q.pop_front()));
    endtask

    initial begin
        bus4.A = 4'd5;
        bus4.B = 4'd3;
        bus4.Ci = 1'b1;
        bus8.A = 8'd0;
        bus8.B = 8'd0;
        bus8.Ci = 1'b0;
        step(4'd5, 4'd3, 1'b1, 1'b1, "reset_a");
        step(4'd5, 4'd3, 1'b1, 1'b1, "reset_b");
        step(4'd5, 4'd3, 1'b1, 1'b0, "release");
        step(4'd7, 4'd8, 1'b0, 1'b0, "no_carry");
        step(4'd15, 4'd15, 1'b1, 1'b0, "all_ones");
        step(4'd1, 4'd15, 1'b0, 1'b0, "full_ripple");
        step(4'd15, 4'd0, 1'b1, 1'b0, "carry_prop");
        step(4'd3, 4'd4, 1'b0, 1'b0, "stream_0");
        step(4'd10, 4'd6, 1'b0, 1'b0, "stream_1");
        step(4'd0, 4'd0, 1'b1, 1'b0, "stream_2");
        step(4'd12, 4'd9, 1'b0, 1'b1, "mid_reset");
        step(4'd12, 4'd9, 1'b0, 1'b0, "after_reset");
        for (int v = 0; v < 512; v++) step(v[3:0], v[7:4], v[8], 1'b0, "sweep");
        @(negedge clk);
        bus8.A = 8'd255;
        bus8.B = 8'd1;
        bus8.Ci = 1'b0;
        @(posedge clk);
        #1;
        check("n8_wrap", {bus8.Co, bus8.S}, 9'h100);
        check("queue_empty", 9'(exp_q.size()), 9'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
